// File: rtl/copperv_pkg.sv
// rtl/copperv_pkg.sv - shared types, compare flag indices and branch decode for the execute/commit stage
package copperv_pkg;

    localparam int alu_comp_eq  = 0;
    localparam int alu_comp_lt  = 1;
    localparam int alu_comp_ltu = 2;

    typedef enum logic [1:0] {RESULT_NONE, RESULT_ALU, RESULT_PC4, RESULT_LOAD} result_sel_t;

    typedef enum logic [3:0] {
        BRANCH_NONE, BRANCH_EQ, BRANCH_NE, BRANCH_LT, BRANCH_GE,
        BRANCH_LTU, BRANCH_GEU, BRANCH_JAL, BRANCH_JALR
    } branch_cond_t;

    typedef enum logic [1:0] {MEM_OP_NONE, MEM_OP_LOAD, MEM_OP_STORE} mem_op_t;

    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} mem_size_t;

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT} state_t;

    function automatic logic branch_taken_f(branch_cond_t cond, logic [2:0] comp);
        case (cond)
            BRANCH_EQ:   return comp[alu_comp_eq];
            BRANCH_NE:   return !comp[alu_comp_eq];
            BRANCH_LT:   return comp[alu_comp_lt];
            BRANCH_GE:   return !comp[alu_comp_lt];
            BRANCH_LTU:  return comp[alu_comp_ltu];
            BRANCH_GEU:  return !comp[alu_comp_ltu];
            BRANCH_JAL,
            BRANCH_JALR: return 1'b1;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_commit_if.sv
// rtl/execute_commit_if.sv - data memory request/response bus
interface execute_commit_if #(
    parameter int data_width = 32,
    parameter int addr_width = 32
) ();
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [addr_width-1:0] mem_req_addr;
    logic                  mem_req_we;
    logic [data_width-1:0] mem_req_wdata;
    logic [3:0]            mem_req_strobe;
    logic                  mem_resp_valid;
    logic [data_width-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_strobe,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_strobe,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/execute_commit_load_store_align.sv
// rtl/execute_commit_load_store_align.sv - byte-lane placement for stores, extraction and extension for loads
module load_store_align
    import copperv_pkg::*;
#(
    parameter int data_width = 32
) (
    input  logic [1:0]            addr_lo,
    input  mem_size_t             mem_size,
    input  logic                  load_unsigned,
    input  logic [data_width-1:0] store_data,
    input  logic [data_width-1:0] resp_data,
    output logic [data_width-1:0] wdata,
    output logic [3:0]            strobe,
    output logic [data_width-1:0] load_data,
    output logic                  misaligned
);
    logic [data_width-1:0] shifted;

    always_comb begin
        shifted = resp_data >> {addr_lo, 3'b000};
        case (mem_size)
            SIZE_BYTE: begin
                wdata      = {(data_width/8){store_data[7:0]}};
                strobe     = 4'b0001 << addr_lo;
                misaligned = 1'b0;
                load_data  = load_unsigned ? {{(data_width-8){1'b0}}, shifted[7:0]}
                                           : {{(data_width-8){shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                wdata      = {(data_width/16){store_data[15:0]}};
                strobe     = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
                load_data  = load_unsigned ? {{(data_width-16){1'b0}}, shifted[15:0]}
                                           : {{(data_width-16){shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata      = store_data;
                strobe     = 4'b1111;
                misaligned = (addr_lo != 2'b00);
                load_data  = shifted;
            end
        endcase
    end
endmodule

// File: rtl/execute_commit.sv
// rtl/execute_commit.sv - execute/commit stage: branch resolution, memory access FSM, register-file writeback
module execute_commit
    import copperv_pkg::*;
#(
    parameter int data_width     = 32,
    parameter int addr_width     = 32,
    parameter int reg_addr_width = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [data_width-1:0]     alu_dout,
    input  logic [2:0]                alu_comp,
    input  logic [addr_width-1:0]     pc,
    input  logic [data_width-1:0]     imm,
    input  logic [reg_addr_width-1:0] rd,
    input  result_sel_t               result_sel,
    input  branch_cond_t              branch_cond,
    input  mem_op_t                   mem_op,
    input  mem_size_t                 mem_size,
    input  logic                      load_unsigned,
    input  logic [data_width-1:0]     store_data,
    execute_commit_if.master          bus,
    output logic                      rf_wr_en,
    output logic [reg_addr_width-1:0] rf_wr_addr,
    output logic [data_width-1:0]     rf_wr_data,
    output logic                      pc_next_valid,
    output logic [addr_width-1:0]     pc_next,
    output logic                      branch_taken,
    output logic                      misaligned
);
    state_t state, state_nx;

    // Op fields held while a memory access is in flight.
    logic [reg_addr_width-1:0] op_rd;
    result_sel_t               op_result_sel;
    branch_cond_t              op_cond;
    mem_op_t                   op_mem;
    mem_size_t                 op_size;
    logic                      op_unsigned;
    logic [2:0]                op_comp;
    logic [addr_width-1:0]     op_pc;
    logic [data_width-1:0]     op_imm, op_alu;

    // In IDLE the live inputs describe the op; afterwards the held copy does.
    logic                      idle;
    logic [reg_addr_width-1:0] cur_rd;
    result_sel_t               cur_result_sel;
    branch_cond_t              cur_cond;
    mem_op_t                   cur_mem;
    mem_size_t                 cur_size;
    logic                      cur_unsigned;
    logic [2:0]                cur_comp;
    logic [addr_width-1:0]     cur_pc;
    logic [data_width-1:0]     cur_imm, cur_alu;

    assign idle           = (state == IDLE);
    assign in_ready       = idle;
    assign cur_rd         = idle ? rd : op_rd;
    assign cur_result_sel = idle ? result_sel : op_result_sel;
    assign cur_cond       = idle ? branch_cond : op_cond;
    assign cur_mem        = idle ? mem_op : op_mem;
    assign cur_size       = idle ? mem_size : op_size;
    assign cur_unsigned   = idle ? load_unsigned : op_unsigned;
    assign cur_comp       = idle ? alu_comp : op_comp;
    assign cur_pc         = idle ? pc : op_pc;
    assign cur_imm        = idle ? imm : op_imm;
    assign cur_alu        = idle ? alu_dout : op_alu;

    logic [addr_width-1:0] mem_addr, pc4, pc_next_nx;
    logic [data_width-1:0] lane_wdata, load_data, rf_data_nx;
    logic [3:0]            lane_strobe;
    logic                  align_fault, is_mem, misal, accept, commit, taken, wr_en_nx;

    assign mem_addr = cur_alu[addr_width-1:0];

    load_store_align #(.data_width(data_width)) u_align (
        .addr_lo       (mem_addr[1:0]),
        .mem_size      (cur_size),
        .load_unsigned (cur_unsigned),
        .store_data    (store_data),
        .resp_data     (bus.mem_resp_data),
        .wdata         (lane_wdata),
        .strobe        (lane_strobe),
        .load_data     (load_data),
        .misaligned    (align_fault)
    );

    always_comb begin
        state_nx   = state;
        commit     = 1'b0;
        is_mem     = (cur_mem != MEM_OP_NONE);
        misal      = is_mem && align_fault;
        accept     = idle && in_valid;
        pc4        = cur_pc + addr_width'(4);
        taken      = branch_taken_f(cur_cond, cur_comp) && !misal;
        pc_next_nx = pc4;
        rf_data_nx = '0;

        case (state)
            IDLE: if (accept) begin
                if (is_mem && !misal) state_nx = MEM_REQ;
                else                  commit   = 1'b1;
            end
            MEM_REQ: if (bus.mem_req_ready) begin
                if (op_mem == MEM_OP_STORE) begin
                    commit   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = MEM_WAIT;
                end
            end
            MEM_WAIT: if (bus.mem_resp_valid) begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (taken)
            pc_next_nx = (cur_cond == BRANCH_JALR) ? {mem_addr[addr_width-1:1], 1'b0}
                                                  : cur_pc + cur_imm[addr_width-1:0];

        case (cur_result_sel)
            RESULT_ALU:  rf_data_nx = cur_alu;
            RESULT_PC4:  rf_data_nx = data_width'(pc4);
            RESULT_LOAD: rf_data_nx = load_data;
            default:     rf_data_nx = '0;
        endcase

        wr_en_nx = commit && !misal && (cur_result_sel != RESULT_NONE) && (cur_rd != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            rf_wr_en           <= 1'b0;
            rf_wr_addr         <= '0;
            rf_wr_data         <= '0;
            pc_next_valid      <= 1'b0;
            pc_next            <= '0;
            branch_taken       <= 1'b0;
            misaligned         <= 1'b0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_req_addr   <= '0;
            bus.mem_req_we     <= 1'b0;
            bus.mem_req_wdata  <= '0;
            bus.mem_req_strobe <= '0;
            op_rd              <= '0;
            op_result_sel      <= RESULT_NONE;
            op_cond            <= BRANCH_NONE;
            op_mem             <= MEM_OP_NONE;
            op_size            <= SIZE_BYTE;
            op_unsigned        <= 1'b0;
            op_comp            <= '0;
            op_pc              <= '0;
            op_imm             <= '0;
            op_alu             <= '0;
        end else begin
            state         <= state_nx;
            rf_wr_en      <= wr_en_nx;
            pc_next_valid <= commit;
            misaligned    <= commit && misal;
            if (commit) begin
                rf_wr_addr   <= cur_rd;
                rf_wr_data   <= rf_data_nx;
                pc_next      <= pc_next_nx;
                branch_taken <= taken;
            end
            if (accept) begin
                op_rd         <= rd;
                op_result_sel <= result_sel;
                op_cond       <= branch_cond;
                op_mem        <= mem_op;
                op_size       <= mem_size;
                op_unsigned   <= load_unsigned;
                op_comp       <= alu_comp;
                op_pc         <= pc;
                op_imm        <= imm;
                op_alu        <= alu_dout;
            end
            if (accept && is_mem && !misal) begin
                bus.mem_req_valid  <= 1'b1;
                bus.mem_req_addr   <= mem_addr;
                bus.mem_req_we     <= (mem_op == MEM_OP_STORE);
                bus.mem_req_wdata  <= (mem_op == MEM_OP_STORE) ? lane_wdata : '0;
                bus.mem_req_strobe <= lane_strobe;
            end else if (state == MEM_REQ && bus.mem_req_ready) begin
                bus.mem_req_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_execute_commit.sv
// tb/tb_execute_commit.sv - directed-vector bench for execute_commit
module tb_execute_commit;
    import copperv_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [31:0]  alu_dout, pc, imm, store_data;
    logic [2:0]   alu_comp;
    logic [4:0]   rd;
    result_sel_t  result_sel;
    branch_cond_t branch_cond;
    mem_op_t      mem_op;
    mem_size_t    mem_size;
    logic         load_unsigned;
    logic         rf_wr_en, pc_next_valid, branch_taken, misaligned;
    logic [4:0]   rf_wr_addr;
    logic [31:0]  rf_wr_data, pc_next;

    int n_vec = 0;
    int n_err = 0;

    execute_commit_if #(.data_width(32), .addr_width(32)) bus ();

    execute_commit dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_dout      (alu_dout),
        .alu_comp      (alu_comp),
        .pc            (pc),
        .imm           (imm),
        .rd            (rd),
        .result_sel    (result_sel),
        .branch_cond   (branch_cond),
        .mem_op        (mem_op),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .store_data    (store_data),
        .bus           (bus),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .pc_next_valid (pc_next_valid),
        .pc_next       (pc_next),
        .branch_taken  (branch_taken),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one accepting edge; returns #1 after that edge.
    task automatic issue(input result_sel_t rs, input logic [4:0] r, input branch_cond_t bc,
                         input mem_op_t mo, input mem_size_t ms, input logic lu,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] alu,
                         input logic [2:0] cmp, input logic [31:0] sd);
        result_sel    = rs;
        rd            = r;
        branch_cond   = bc;
        mem_op        = mo;
        mem_size      = ms;
        load_unsigned = lu;
        pc            = p;
        imm           = im;
        alu_dout      = alu;
        alu_comp      = cmp;
        store_data    = sd;
        in_valid      = 1'b1;
        tick();
        in_valid      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        alu_dout = '0; pc = '0; imm = '0; store_data = '0; alu_comp = '0; rd = '0;
        result_sel = RESULT_NONE; branch_cond = BRANCH_NONE; mem_op = MEM_OP_NONE;
        mem_size = SIZE_BYTE; load_unsigned = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_wr_en", rf_wr_en, 0);
        chk("rst_pc_next_valid", pc_next_valid, 0);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_pc_next", pc_next, 0);
        rst = 1'b0;
        tick();

        issue(RESULT_ALU, 5'd5, BRANCH_NONE, MEM_OP_NONE, SIZE_WORD, 0, 32'h200, 0, 32'h1234, 3'b000, 0);
        chk("add_wr_en", rf_wr_en, 1);
        chk("add_wr_addr", rf_wr_addr, 5);
        chk("add_wr_data", rf_wr_data, 32'h1234);
        chk("add_pc_next", pc_next, 32'h204);
        chk("add_pc_valid", pc_next_valid, 1);
        chk("add_in_ready", in_ready, 1);
        tick();
        chk("add_wr_en_pulse", rf_wr_en, 0);
        chk("add_pc_valid_pulse", pc_next_valid, 0);

        issue(RESULT_NONE, 5'd0, BRANCH_NE, MEM_OP_NONE, SIZE_WORD, 0, 32'h100, 32'h20, 0, 3'b000, 0);
        chk("bne_taken", branch_taken, 1);
        chk("bne_pc_next", pc_next, 32'h120);
        chk("bne_wr_en", rf_wr_en, 0);
        issue(RESULT_NONE, 5'd0, BRANCH_NE, MEM_OP_NONE, SIZE_WORD, 0, 32'h100, 32'h20, 0, 3'b001, 0);
        chk("bne_nt_taken", branch_taken, 0);
        chk("bne_nt_pc_next", pc_next, 32'h104);

        issue(RESULT_PC4, 5'd1, BRANCH_JAL, MEM_OP_NONE, SIZE_WORD, 0, 32'h300, 32'h40, 0, 3'b000, 0);
        chk("jal_pc_next", pc_next, 32'h340);
        chk("jal_link", rf_wr_data, 32'h304);
        issue(RESULT_PC4, 5'd1, BRANCH_JALR, MEM_OP_NONE, SIZE_WORD, 0, 32'h400, 0, 32'h1235, 3'b000, 0);
        chk("jalr_pc_next", pc_next, 32'h1234);
        chk("jalr_link", rf_wr_data, 32'h404);
        issue(RESULT_NONE, 5'd0, BRANCH_LTU, MEM_OP_NONE, SIZE_WORD, 0, 32'h500, 32'hFFFF_FFF0, 0, 3'b100, 0);
        chk("bltu_pc_next", pc_next, 32'h4F0);
        issue(RESULT_NONE, 5'd0, BRANCH_GE, MEM_OP_NONE, SIZE_WORD, 0, 32'h500, 32'h10, 0, 3'b010, 0);
        chk("bge_nt_pc_next", pc_next, 32'h504);
        issue(RESULT_ALU, 5'd0, BRANCH_NONE, MEM_OP_NONE, SIZE_WORD, 0, 32'h600, 0, 32'h77, 3'b000, 0);
        chk("rd0_wr_en", rf_wr_en, 0);
        chk("rd0_pc_valid", pc_next_valid, 1);

        issue(RESULT_LOAD, 5'd7, BRANCH_NONE, MEM_OP_LOAD, SIZE_BYTE, 0, 32'h600, 0, 32'h1003, 3'b000, 0);
        chk("lb_in_ready", in_ready, 0);
        chk("lb_pc_valid", pc_next_valid, 0);
        for (int i = 0; i < 3; i++) begin
            chk("lb_req_valid", bus.mem_req_valid, 1);
            chk("lb_req_addr", bus.mem_req_addr, 32'h1003);
            chk("lb_req_we", bus.mem_req_we, 0);
            chk("lb_req_strobe", bus.mem_req_strobe, 4'b1000);
            tick();
        end
        chk("lb_req_held", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("lb_req_dropped", bus.mem_req_valid, 0);
        chk("lb_wait_no_wr", rf_wr_en, 0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h8000_0000;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("lb_wr_en", rf_wr_en, 1);
        chk("lb_wr_addr", rf_wr_addr, 7);
        chk("lb_wr_data", rf_wr_data, 32'hFFFF_FF80);
        chk("lb_pc_next", pc_next, 32'h604);
        chk("lb_in_ready_back", in_ready, 1);

        issue(RESULT_LOAD, 5'd8, BRANCH_NONE, MEM_OP_LOAD, SIZE_HALF, 1, 32'h640, 0, 32'h1002, 3'b000, 0);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hBEEF_0000;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("lhu_wr_data", rf_wr_data, 32'h0000_BEEF);

        issue(RESULT_NONE, 5'd0, BRANCH_NONE, MEM_OP_STORE, SIZE_HALF, 0, 32'h700, 0, 32'h1002, 3'b000, 32'hABCD);
        chk("sh_req_valid", bus.mem_req_valid, 1);
        chk("sh_strobe", bus.mem_req_strobe, 4'b1100);
        chk("sh_wdata", bus.mem_req_wdata, 32'hABCD_ABCD);
        chk("sh_we", bus.mem_req_we, 1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("sh_commit", pc_next_valid, 1);
        chk("sh_pc_next", pc_next, 32'h704);
        chk("sh_no_wr", rf_wr_en, 0);
        chk("sh_req_done", bus.mem_req_valid, 0);
        chk("sh_in_ready", in_ready, 1);

        issue(RESULT_LOAD, 5'd3, BRANCH_NONE, MEM_OP_LOAD, SIZE_WORD, 0, 32'h800, 0, 32'h1001, 3'b000, 0);
        chk("lw_mis_pulse", misaligned, 1);
        chk("lw_mis_no_req", bus.mem_req_valid, 0);
        chk("lw_mis_no_wr", rf_wr_en, 0);
        chk("lw_mis_pc_next", pc_next, 32'h804);
        chk("lw_mis_pc_valid", pc_next_valid, 1);
        tick();
        chk("lw_mis_pulse_end", misaligned, 0);

        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h1111_1111;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("stray_idle_wr", rf_wr_en, 0);
        chk("stray_idle_commit", pc_next_valid, 0);

        issue(RESULT_LOAD, 5'd9, BRANCH_NONE, MEM_OP_LOAD, SIZE_WORD, 0, 32'h900, 0, 32'h2000, 3'b000, 0);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("rstw_in_wait", in_ready, 0);
        rst = 1'b1;
        #2;
        chk("rstw_in_ready", in_ready, 1);
        chk("rstw_pc_next", pc_next, 0);
        chk("rstw_wr_data", rf_wr_data, 0);
        rst = 1'b0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h5555_5555;
        tick();
        bus.mem_resp_valid = 1'b0;
        chk("rstw_no_wr", rf_wr_en, 0);
        chk("rstw_no_commit", pc_next_valid, 0);
        chk("rstw_wr_data_zero", rf_wr_data, 0);
        chk("rstw_in_ready_after", in_ready, 1);
        chk("rstw_req_valid", bus.mem_req_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/execute_commit.md
EXECUTE_COMMIT -- requirements
Module: execute_commit

Interface
REQ-001 Parameter data_width, default 32, datapath and bus data width.
REQ-002 Parameter addr_width, default 32, PC and memory address width.
REQ-003 Parameter reg_addr_width, default 5, register index width.
REQ-004 Port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Ports in_valid input 1 / in_ready output 1: operation handshake, transfer when both high at a clk edge.
REQ-007 Port alu_dout input data_width: ALU result, also the memory address and JALR target.
REQ-008 Port alu_comp input 3: compare flags at package indices alu_comp_eq, alu_comp_lt, alu_comp_ltu.
REQ-009 Ports pc input addr_width, imm input data_width: current PC and decoded immediate.
REQ-010 Ports rd input reg_addr_width, result_sel input result_sel_t (NONE/ALU/PC4/LOAD), branch_cond input branch_cond_t (NONE/EQ/NE/LT/GE/LTU/GEU/JAL/JALR).
REQ-011 Ports mem_op input mem_op_t (NONE/LOAD/STORE), mem_size input mem_size_t (BYTE/HALF/WORD), load_unsigned input 1, store_data input data_width.
REQ-012 Ports mem_req_valid output 1, mem_req_ready input 1, mem_req_addr output addr_width, mem_req_we output 1, mem_req_wdata output data_width, mem_req_strobe output 4.
REQ-013 Ports mem_resp_valid input 1, mem_resp_data input data_width: read response, always accepted.
REQ-014 Ports rf_wr_en output 1, rf_wr_addr output reg_addr_width, rf_wr_data output data_width: register-file write.
REQ-015 Ports pc_next_valid output 1, pc_next output addr_width, branch_taken output 1, misaligned output 1.

Function
REQ-016 FSM states IDLE, MEM_REQ, MEM_WAIT; in_ready SHALL be 1 only in IDLE.
REQ-017 Accepted op with mem_op=NONE: commit outputs SHALL be driven in the cycle after acceptance, state stays IDLE.
REQ-018 Commit outputs (rf_wr_en, pc_next_valid, misaligned) SHALL be single-cycle pulses, registered.
REQ-019 Taken condition: EQ=eq, NE=!eq, LT=lt, GE=!lt, LTU=ltu, GEU=!ltu, JAL/JALR=1, NONE=0.
REQ-020 pc_next SHALL be pc+imm for taken EQ..JAL, {alu_dout[addr_width-1:1],1'b0} for JALR, else pc+4; pc_next_valid pulses on every commit.
REQ-021 rf write data: ALU -> alu_dout, PC4 -> pc+4, LOAD -> extracted load data; rf_wr_en SHALL be 0 when result_sel=NONE or rd=0.
REQ-022 Misaligned when HALF with addr[0]=1 or WORD with addr[1:0]!=0: no bus request, no rf write, misaligned pulses with commit, pc_next=pc+4.
REQ-023 Aligned LOAD/STORE: IDLE -> MEM_REQ; mem_req_valid held high with stable fields until mem_req_ready.
REQ-024 STORE: on request acceptance commit in the next cycle, return to IDLE; no response awaited.
REQ-025 LOAD: on acceptance go MEM_WAIT; on mem_resp_valid commit in the next cycle and return to IDLE.
REQ-026 Store lanes: wdata = store_data replicated per size, strobe BYTE=0001<<addr[1:0], HALF=0011<<addr[1:0], WORD=1111; mem_req_we=1 only for STORE.
REQ-027 Load extract: shift mem_resp_data right by 8*addr[1:0], zero-extend if load_unsigned, else sign-extend from bit 7/15.
REQ-028 mem_resp_valid outside MEM_WAIT SHALL be ignored.

Reset
REQ-029 rst SHALL force state IDLE and zero every output except in_ready, which SHALL be 1.
REQ-030 Reset mid-transaction SHALL abandon it: no commit, later stray response ignored.

Structure
REQ-031 result_sel_t, branch_cond_t, mem_op_t, mem_size_t, FSM state type in copperv_pkg next to existing alu_comp_* indices.
REQ-032 One sub-module, load_store_align (combinational lane shift, strobe, extension); FSM and commit registers in execute_commit.

Verification
REQ-033 ADD: result_sel=ALU, rd=5, alu_dout=0x1234 -> next cycle rf_wr_en=1, addr 5, data 0x1234, pc_next=pc+4.
REQ-034 BNE pc=0x100 imm=0x20 eq=0 -> branch_taken=1, pc_next=0x120; eq=1 -> pc_next=0x104.
REQ-035 LB addr=0x1003, resp 0x80000000, load_unsigned=0, ready delayed 3 cycles -> req held stable, rf data 0xFFFFFF80.
REQ-036 SH addr=0x1002 store_data=0xABCD -> strobe 1100, wdata 0xABCDABCD, we=1; LW addr=0x1001 -> misaligned pulse, no request.
REQ-037 rst asserted in MEM_WAIT, resp arrives after release -> no rf write, in_ready=1, outputs zero.
